// File: rtl/cordic_sched_pkg.sv
// Shared constants for the CORDIC scheduler: core opcodes, default sizing and FSM state type.
package cordic_sched_pkg;

    localparam logic [1:0] OP_P2R   = 2'd0;
    localparam logic [1:0] OP_R2P   = 2'd1;
    localparam logic [1:0] OP_SLAVE = 2'd3;

    localparam int DEF_WIDTH = 19;

    // Core stage count is WIDTH+3 (one rotation per bit plus pre/post stages).
    function automatic int cordic_lat(input int width);
        return width + 3;
    endfunction

    localparam int DEF_LAT = cordic_lat(DEF_WIDTH);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } sched_state_e;

endpackage

// File: rtl/cordic_sched_if.sv
// Requester, core and result bundle of the CORDIC scheduler; slave = scheduler side.
interface cordic_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 19
);
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            req_pair;
    logic [2*NREQ-1:0]          req_op;
    logic [WIDTH*NREQ-1:0]      req_x;
    logic [WIDTH*NREQ-1:0]      req_y;
    logic [(WIDTH+1)*NREQ-1:0]  req_ph;
    logic [NREQ-1:0]            gnt;
    logic [1:0]                 cor_op;
    logic [WIDTH-1:0]           cor_x;
    logic [WIDTH-1:0]           cor_y;
    logic [WIDTH:0]             cor_ph;
    logic [WIDTH-1:0]           cor_xo;
    logic [WIDTH-1:0]           cor_yo;
    logic [WIDTH:0]             cor_pho;
    logic [NREQ-1:0]            res_valid;
    logic [WIDTH-1:0]           res_x;
    logic [WIDTH-1:0]           res_y;
    logic [WIDTH:0]             res_ph;
    logic                       pair_err;

    modport slave (
        input  req, req_pair, req_op, req_x, req_y, req_ph, cor_xo, cor_yo, cor_pho,
        output gnt, cor_op, cor_x, cor_y, cor_ph, res_valid, res_x, res_y, res_ph, pair_err
    );

    modport master (
        output req, req_pair, req_op, req_x, req_y, req_ph, cor_xo, cor_yo, cor_pho,
        input  gnt, cor_op, cor_x, cor_y, cor_ph, res_valid, res_x, res_y, res_ph, pair_err
    );
endinterface

// File: rtl/cordic_sched_rr_arb.sv
// Round-robin arbiter with a lock override that pins the grant to one owner.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            lock_i,
    input  logic [IDW-1:0]  lock_id_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW:0]   sum;
    logic [IDW:0]   nxt;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        ptr_d     = ptr_q;
        sum       = '0;
        nxt       = '0;
        if (!rst) begin
            if (lock_i) begin
                if (req_i[lock_id_i]) begin
                    gnt_id_o  = lock_id_i;
                    gnt_vld_o = 1'b1;
                end
            end else begin
                // Scan from farthest to nearest so the requester closest to the pointer wins.
                for (int k = NREQ - 1; k >= 0; k--) begin
                    sum = {1'b0, ptr_q} + (IDW+1)'(k);
                    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
                    if (req_i[sum[IDW-1:0]]) begin
                        gnt_id_o  = sum[IDW-1:0];
                        gnt_vld_o = 1'b1;
                    end
                end
                if (gnt_vld_o) begin
                    nxt   = {1'b0, gnt_id_o} + (IDW+1)'(1);
                    ptr_d = (nxt == (IDW+1)'(NREQ)) ? '0 : nxt[IDW-1:0];
                end
            end
            if (gnt_vld_o) gnt_o[gnt_id_o] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one pipelined CORDIC core among NREQ requesters; results return via a tag delay line.
//   state   | meaning
//   ST_ARB  | round-robin arbitration among all requesters
//   ST_LOCK | slave beat reserved for the master granted in the previous cycle
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input logic           clk,
    input logic           rst,
    cordic_sched_if.slave bus
);

    sched_state_e     state_q;
    logic [IDW-1:0]   lock_id_q;
    logic             pair_err_q;
    logic [1:0]       cor_op_q;
    logic [WIDTH-1:0] cor_x_q, cor_y_q;
    logic [WIDTH:0]   cor_ph_q;
    logic [LAT:0]     tag_vld_q;
    logic [IDW-1:0]   tag_id_q [LAT+1];
    logic [NREQ-1:0]  res_valid_q;
    logic [WIDTH-1:0] res_x_q, res_y_q;
    logic [WIDTH:0]   res_ph_q;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_vld;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_x, sel_y;
    logic [WIDTH:0]   sel_ph;
    logic             sel_pair;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req),
        .lock_i    (state_q == ST_LOCK),
        .lock_id_i (lock_id_q),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        sel_op   = '0;
        sel_x    = '0;
        sel_y    = '0;
        sel_ph   = '0;
        sel_pair = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_op   = bus.req_op[2*i +: 2];
                sel_x    = bus.req_x[WIDTH*i +: WIDTH];
                sel_y    = bus.req_y[WIDTH*i +: WIDTH];
                sel_ph   = bus.req_ph[(WIDTH+1)*i +: (WIDTH+1)];
                sel_pair = bus.req_pair[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            lock_id_q   <= '0;
            pair_err_q  <= 1'b0;
            cor_op_q    <= OP_P2R;
            cor_x_q     <= '0;
            cor_y_q     <= '0;
            cor_ph_q    <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k <= LAT; k++) tag_id_q[k] <= '0;
            res_valid_q <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            res_ph_q    <= '0;
        end else begin
            // Tag tail lines up with the core output of the same operation.
            tag_vld_q   <= {tag_vld_q[LAT-1:0], gnt_vld};
            tag_id_q[0] <= gnt_id;
            for (int k = 1; k <= LAT; k++) tag_id_q[k] <= tag_id_q[k-1];

            if (gnt_vld) begin
                cor_op_q <= (state_q == ST_LOCK) ? OP_SLAVE : sel_op;
                cor_x_q  <= sel_x;
                cor_y_q  <= sel_y;
                cor_ph_q <= sel_ph;
            end else begin
                cor_op_q <= OP_P2R;
                cor_x_q  <= '0;
                cor_y_q  <= '0;
                cor_ph_q <= '0;
            end

            case (state_q)
                ST_ARB: begin
                    if (gnt_vld && sel_pair) begin
                        state_q   <= ST_LOCK;
                        lock_id_q <= gnt_id;
                    end
                end
                ST_LOCK: begin
                    state_q <= ST_ARB;
                    if (!gnt_vld) pair_err_q <= 1'b1;
                end
                default: state_q <= ST_ARB;
            endcase

            res_valid_q <= '0;
            if (tag_vld_q[LAT]) begin
                res_valid_q[tag_id_q[LAT]] <= 1'b1;
                res_x_q  <= bus.cor_xo;
                res_y_q  <= bus.cor_yo;
                res_ph_q <= bus.cor_pho;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.cor_op    = cor_op_q;
    assign bus.cor_x     = cor_x_q;
    assign bus.cor_y     = cor_y_q;
    assign bus.cor_ph    = cor_ph_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_x     = res_x_q;
    assign bus.res_y     = res_y_q;
    assign bus.res_ph    = res_ph_q;
    assign bus.pair_err  = pair_err_q;

endmodule
